// File: rtl/vrf_read_request_sequencer.sv
// Expands one VRF read command into a register-group sequence of read requests.
// It issues one request per cycle under ready/valid and reports completion per instruction.
module vrf_read_request_sequencer #(
  parameter int unsigned VS_WIDTH    = 5,
  parameter int unsigned COUNT_WIDTH = 4,
  parameter int unsigned MAX_REGS    = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [VS_WIDTH-1:0]    cmd_bits_vsBase,
  input  logic [COUNT_WIDTH-1:0] cmd_bits_regCount,
  input  logic [1:0]             cmd_bits_readSource,
  input  logic [2:0]             cmd_bits_instructionIndex,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [VS_WIDTH-1:0]    req_bits_vs,
  output logic [1:0]             req_bits_readSource,
  output logic [2:0]             req_bits_instructionIndex,
  input  logic                   kill_valid,
  input  logic [2:0]             kill_bits_instructionIndex,
  output logic                   done_valid,
  output logic [2:0]             done_bits_instructionIndex,
  output logic                   busy
);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  localparam logic [COUNT_WIDTH-1:0] MaxRegs = COUNT_WIDTH'(MAX_REGS);

  state_e                 r_state;
  logic [COUNT_WIDTH-1:0] r_offset;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [VS_WIDTH-1:0]    r_vs_base;
  logic [1:0]             r_src;
  logic [2:0]             r_idx;
  logic                   r_done_valid;
  logic [2:0]             r_done_idx;

  state_e                 w_state_next;
  logic [COUNT_WIDTH-1:0] w_offset_next;
  logic [COUNT_WIDTH-1:0] w_count_next;
  logic [VS_WIDTH-1:0]    w_vs_base_next;
  logic [1:0]             w_src_next;
  logic [2:0]             w_idx_next;
  logic                   w_done_valid_next;
  logic [2:0]             w_done_idx_next;

  logic                   w_cmd_fire;
  logic                   w_req_fire;
  logic                   w_last;
  logic                   w_kill;
  logic [COUNT_WIDTH-1:0] w_eff_count;

  always_comb begin
    cmd_ready                  = (r_state == StIdle);
    req_valid                  = (r_state == StIssue);
    busy                       = (r_state != StIdle);
    req_bits_vs                = r_vs_base + VS_WIDTH'(r_offset);
    req_bits_readSource        = r_src;
    req_bits_instructionIndex  = r_idx;
    done_valid                 = r_done_valid;
    done_bits_instructionIndex = r_done_idx;

    w_cmd_fire  = cmd_valid & cmd_ready;
    w_req_fire  = req_valid & req_ready;
    w_last      = (r_offset == (r_count - COUNT_WIDTH'(1)));
    w_kill      = kill_valid & (kill_bits_instructionIndex == r_idx) & (r_state == StIssue);
    w_eff_count = (cmd_bits_regCount > MaxRegs) ? MaxRegs : cmd_bits_regCount;
  end

  always_comb begin
    w_state_next      = r_state;
    w_offset_next     = r_offset;
    w_count_next      = r_count;
    w_vs_base_next    = r_vs_base;
    w_src_next        = r_src;
    w_idx_next        = r_idx;
    w_done_valid_next = 1'b0;
    w_done_idx_next   = r_done_idx;

    unique case (r_state)
      StIdle: begin
        if (w_cmd_fire) begin
          w_vs_base_next = cmd_bits_vsBase;
          w_src_next     = cmd_bits_readSource;
          w_idx_next     = cmd_bits_instructionIndex;
          w_count_next   = w_eff_count;
          w_offset_next  = '0;
          if (w_eff_count == '0) begin
            w_done_valid_next = 1'b1;
            w_done_idx_next   = cmd_bits_instructionIndex;
          end else begin
            w_state_next = StIssue;
          end
        end
      end
      StIssue: begin
        // A final fire completes the group even if a kill lands in the same cycle.
        if (w_req_fire && w_last) begin
          w_state_next      = StIdle;
          w_offset_next     = '0;
          w_done_valid_next = 1'b1;
          w_done_idx_next   = r_idx;
        end else if (w_kill) begin
          w_state_next  = StIdle;
          w_offset_next = '0;
        end else if (w_req_fire) begin
          w_offset_next = r_offset + COUNT_WIDTH'(1);
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= StIdle;
      r_offset     <= '0;
      r_count      <= '0;
      r_vs_base    <= '0;
      r_src        <= '0;
      r_idx        <= '0;
      r_done_valid <= 1'b0;
      r_done_idx   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_offset     <= w_offset_next;
      r_count      <= w_count_next;
      r_vs_base    <= w_vs_base_next;
      r_src        <= w_src_next;
      r_idx        <= w_idx_next;
      r_done_valid <= w_done_valid_next;
      r_done_idx   <= w_done_idx_next;
    end
  end

endmodule
